// File: rtl/btn_evt_pkg.sv
// Shared event codes and channel state encodings
// for the panel button event controller.
package btn_evt_pkg;

  localparam logic [1:0] EVT_SHORT = 2'b01;
  localparam logic [1:0] EVT_LONG  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_HELD      = 2'd1,
    ST_LONG_WAIT = 2'd2
  } ch_state_e;

endpackage

// File: rtl/button_event_ctrl_channel.sv
// One button channel: debouncer, edge detect, hold timer,
// press classifier and a one-deep pending event slot.
// btn_debounce: noisy -> clean after TARGET_TIME+1 mismatches.
// btn_channel: in noisy, clear; out clean, pend, pend_type, ovf.
module btn_debounce #(
  parameter int TARGET_TIME = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic noisy,
  output logic clean
);

  localparam int W = $clog2(TARGET_TIME + 1) + 1;

  logic [W-1:0] cnt;

  // Any sample equal to the clean level restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (noisy != clean) begin
      if (cnt == W'(TARGET_TIME)) begin
        clean <= noisy;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int CNT_W             = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       noisy,
  input  logic       clear,
  output logic       clean,
  output logic       pend,
  output logic [1:0] pend_type,
  output logic       ovf
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(LONG_PRESS_CYCLES - 1);

  ch_state_e        state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_nx;
  logic             clean_q;
  logic             rise, fall;
  logic             post;
  logic [1:0]       post_type;

  btn_debounce #(
    .TARGET_TIME(DEBOUNCE_CYCLES)
  ) u_db (
    .clk  (clk),
    .reset(reset),
    .noisy(noisy),
    .clean(clean)
  );

  assign rise = clean & ~clean_q;
  assign fall = ~clean & clean_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      clean_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      hold_cnt <= hold_nx;
      clean_q  <= clean;
    end
  end

  always_comb begin
    state_nx  = state;
    hold_nx   = hold_cnt;
    post      = 1'b0;
    post_type = EVT_SHORT;
    unique case (state)
      ST_IDLE: begin
        if (rise) begin
          state_nx = ST_HELD;
          hold_nx  = '0;
        end
      end
      ST_HELD: begin
        hold_nx = hold_cnt + 1'b1;
        // Threshold wins over a coincident release; the
        // release then just returns to idle.
        if (hold_cnt == LAST) begin
          post      = 1'b1;
          post_type = EVT_LONG;
          state_nx  = fall ? ST_IDLE : ST_LONG_WAIT;
        end else if (fall) begin
          post     = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      ST_LONG_WAIT: begin
        hold_nx = hold_cnt;
        if (fall) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // A slot being drained this cycle can take the new event.
  assign ovf = post & pend & ~clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_type <= 2'b00;
    end else if (post && (!pend || clear)) begin
      pend      <= 1'b1;
      pend_type <= post_type;
    end else if (clear) begin
      pend <= 1'b0;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Panel button front end: per-button channels, round-robin
// arbiter and a registered valid/ready event port.
// Ports: clk, reset, btn_noisy, btn_clean, evt_valid,
// evt_ready, evt_id, evt_type, evt_overflow.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN           = 5,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter int CNT_W             = 27,
  parameter int ID_W              = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_noisy,
  output logic [NUM_BTN-1:0] btn_clean,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_type,
  output logic               evt_overflow
);

  localparam int NSLOT = 2 ** ID_W;
  localparam logic [ID_W-1:0] MAX_ID = ID_W'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] pend;
  logic [NUM_BTN-1:0] clear;
  logic [NUM_BTN-1:0] ovf;
  logic [1:0]         ptype [NUM_BTN];

  logic [NSLOT-1:0]   pend_ext;
  logic [1:0]         ptype_ext [NSLOT];

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    idx;
  logic               any;
  logic               slot_free;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES),
      .CNT_W            (CNT_W)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .noisy    (btn_noisy[g]),
      .clear    (clear[g]),
      .clean    (btn_clean[g]),
      .pend     (pend[g]),
      .pend_type(ptype[g]),
      .ovf      (ovf[g])
    );
  end

  // Pad to the full id space so any id indexes safely.
  assign pend_ext = NSLOT'(pend);

  always_comb begin
    for (int i = 0; i < NSLOT; i++) ptype_ext[i] = 2'b00;
    for (int i = 0; i < NUM_BTN; i++) ptype_ext[i] = ptype[i];
  end

  // First pending channel at or after rr_ptr, wrapping.
  always_comb begin
    any = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = 0; k < NUM_BTN; k++) begin
      if (!any && pend_ext[idx]) begin
        any = 1'b1;
        win = idx;
      end
      idx = (idx == MAX_ID) ? '0 : idx + 1'b1;
    end
  end

  assign slot_free = !evt_valid || evt_ready;
  assign clear = (slot_free && any) ?
    (NUM_BTN'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid    <= 1'b0;
      evt_id       <= '0;
      evt_type     <= 2'b00;
      evt_overflow <= 1'b0;
      rr_ptr       <= '0;
    end else begin
      evt_overflow <= |ovf;
      if (slot_free) begin
        evt_valid <= any;
        if (any) begin
          evt_id   <= win;
          evt_type <= ptype_ext[win];
          rr_ptr   <= (win == MAX_ID) ? '0 : win + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed self-checking bench for button_event_ctrl
// with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, NUM_BTN=5.
module tb_button_event_ctrl;

  localparam int NB = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_noisy;
  logic [NB-1:0] btn_clean;
  logic          evt_valid;
  logic          evt_ready;
  logic [2:0]    evt_id;
  logic [1:0]    evt_type;
  logic          evt_overflow;

  int checks = 0;
  int failures = 0;

  logic [4:0] evq [$];
  int vcnt = 0;
  int ocnt = 0;

  button_event_ctrl #(
    .NUM_BTN          (NB),
    .DEBOUNCE_CYCLES  (4),
    .LONG_PRESS_CYCLES(20),
    .CNT_W            (27),
    .ID_W             (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_noisy   (btn_noisy),
    .btn_clean   (btn_clean),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_type    (evt_type),
    .evt_overflow(evt_overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (evt_valid) vcnt <= vcnt + 1;
      if (evt_overflow) ocnt <= ocnt + 1;
      if (evt_valid && evt_ready)
        evq.push_back({evt_id, evt_type});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_noisy = '0;
    evt_ready = 1'b1;
    ticks(3);
    reset = 1'b0;
    tick();
    checks++;
    if (btn_clean !== 5'b0) begin
      failures++;
      $display("FAIL reset_clean got=%b exp=00000", btn_clean);
    end
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", evt_valid);
    end
    checks++;
    if (evt_id !== 3'd0 || evt_type !== 2'b00) begin
      failures++;
      $display("FAIL reset_id_type got=%0d/%b exp=0/00",
               evt_id, evt_type);
    end
    checks++;
    if (evt_overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=0", evt_overflow);
    end
  endtask

  // Rise of clean at tick 5, release at tick 12,
  // clean falls at 17, pend at 18, valid at 19.
  task automatic test_short();
    int q0, v0, o0;
    q0 = evq.size();
    v0 = vcnt;
    o0 = ocnt;
    btn_noisy[2] = 1'b1;
    ticks(4);
    checks++;
    if (btn_clean[2] !== 1'b0) begin
      failures++;
      $display("FAIL short_clean_early got=%b exp=0",
               btn_clean[2]);
    end
    tick();
    checks++;
    if (btn_clean[2] !== 1'b1) begin
      failures++;
      $display("FAIL short_clean_rise got=%b exp=1",
               btn_clean[2]);
    end
    ticks(7);
    btn_noisy[2] = 1'b0;
    ticks(6);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_valid_early got=%b exp=0",
               evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd2 ||
        evt_type !== 2'b01) begin
      failures++;
      $display("FAIL short_event got=%b/%0d/%b exp=1/2/01",
               evt_valid, evt_id, evt_type);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL short_valid_drop got=%b exp=0",
               evt_valid);
    end
    ticks(5);
    checks++;
    if (evq.size() - q0 != 1 || vcnt - v0 != 1 ||
        ocnt - o0 != 0) begin
      failures++;
      $display("FAIL short_counts got=ev%0d/v%0d/o%0d exp=1/1/0",
               evq.size() - q0, vcnt - v0, ocnt - o0);
    end
  endtask

  // Rise detected at tick 6 (cnt 0), cnt 19 after tick 25,
  // pend at 26, valid at 27 while still held.
  task automatic test_long();
    int q0, v0;
    q0 = evq.size();
    v0 = vcnt;
    btn_noisy[0] = 1'b1;
    ticks(26);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL long_valid_early got=%b exp=0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd0 ||
        evt_type !== 2'b10 || btn_clean[0] !== 1'b1) begin
      failures++;
      $display("FAIL long_event got=%b/%0d/%b/%b exp=1/0/10/1",
               evt_valid, evt_id, evt_type, btn_clean[0]);
    end
    ticks(13);
    btn_noisy[0] = 1'b0;
    ticks(12);
    checks++;
    if (evq.size() - q0 != 1 || vcnt - v0 != 1) begin
      failures++;
      $display("FAIL long_release got=ev%0d/v%0d exp=1/1",
               evq.size() - q0, vcnt - v0);
    end
  endtask

  task automatic test_glitch();
    int q0;
    logic hi;
    q0 = evq.size();
    hi = 1'b0;
    for (int i = 0; i < 10; i++) begin
      btn_noisy[1] = ~btn_noisy[1];
      for (int j = 0; j < 3; j++) begin
        tick();
        hi = hi | btn_clean[1];
      end
    end
    btn_noisy[1] = 1'b0;
    ticks(8);
    checks++;
    if (hi !== 1'b0) begin
      failures++;
      $display("FAIL glitch_clean got=%b exp=0", hi);
    end
    checks++;
    if (evq.size() - q0 != 0) begin
      failures++;
      $display("FAIL glitch_events got=%0d exp=0",
               evq.size() - q0);
    end
  endtask

  // Release at tick 8: valid at 15 holding channel 1,
  // then 3 and 4 back to back once ready returns.
  task automatic test_back_to_back();
    int q0;
    q0 = evq.size();
    evt_ready = 1'b0;
    btn_noisy = 5'b11010;
    ticks(8);
    btn_noisy = '0;
    ticks(6);
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_early got=%b exp=0", evt_valid);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd1 ||
        evt_type !== 2'b01) begin
      failures++;
      $display("FAIL b2b_first got=%b/%0d/%b exp=1/1/01",
               evt_valid, evt_id, evt_type);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (evt_valid !== 1'b1 || evt_id !== 3'd1 ||
          evt_type !== 2'b01) begin
        failures++;
        $display("FAIL b2b_stall%0d got=%b/%0d/%b exp=1/1/01",
                 i, evt_valid, evt_id, evt_type);
      end
    end
    evt_ready = 1'b1;
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd3) begin
      failures++;
      $display("FAIL b2b_second got=%b/%0d exp=1/3",
               evt_valid, evt_id);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd4) begin
      failures++;
      $display("FAIL b2b_third got=%b/%0d exp=1/4",
               evt_valid, evt_id);
    end
    tick();
    checks++;
    if (evt_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain got=%b exp=0", evt_valid);
    end
    ticks(2);
    checks++;
    if (evq.size() - q0 != 3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", evq.size() - q0);
    end else begin
      checks++;
      if (evq[q0] !== 5'b001_01 || evq[q0+1] !== 5'b011_01 ||
          evq[q0+2] !== 5'b100_01) begin
        failures++;
        $display("FAIL b2b_order got=%b,%b,%b exp=00101,01101,10001",
                 evq[q0], evq[q0+1], evq[q0+2]);
      end
    end
  endtask

  // Stalled port: press 1 sits in the output register,
  // press 2 in pend, press 3 is dropped.
  task automatic test_overflow();
    int q0, o0, seen;
    q0 = evq.size();
    o0 = ocnt;
    seen = 0;
    evt_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn_noisy[3] = 1'b1;
      ticks(8);
      btn_noisy[3] = 1'b0;
      for (int j = 0; j < 8; j++) begin
        tick();
        if (p == 2 && evt_overflow) seen++;
      end
    end
    checks++;
    if (seen != 1) begin
      failures++;
      $display("FAIL ovf_pulse got=%0d exp=1", seen);
    end
    checks++;
    if (evt_valid !== 1'b1 || evt_id !== 3'd3 ||
        evt_type !== 2'b01) begin
      failures++;
      $display("FAIL ovf_held got=%b/%0d/%b exp=1/3/01",
               evt_valid, evt_id, evt_type);
    end
    evt_ready = 1'b1;
    ticks(4);
    checks++;
    if (evq.size() - q0 != 2 || ocnt - o0 != 1) begin
      failures++;
      $display("FAIL ovf_counts got=ev%0d/o%0d exp=2/1",
               evq.size() - q0, ocnt - o0);
    end else begin
      checks++;
      if (evq[q0] !== 5'b011_01 || evq[q0+1] !== 5'b011_01) begin
        failures++;
        $display("FAIL ovf_events got=%b,%b exp=01101,01101",
                 evq[q0], evq[q0+1]);
      end
    end
  endtask

  // hold_cnt reaches 10 after tick 16; reset lands at 17.
  task automatic test_reset_mid();
    int q0, v0;
    evt_ready = 1'b1;
    btn_noisy[0] = 1'b1;
    ticks(16);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (btn_clean !== 5'b0 || evt_valid !== 1'b0 ||
        evt_id !== 3'd0 || evt_type !== 2'b00 ||
        evt_overflow !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%b/%0d/%b/%b exp=0",
               btn_clean, evt_valid, evt_id, evt_type,
               evt_overflow);
    end
    q0 = evq.size();
    v0 = vcnt;
    btn_noisy[0] = 1'b0;
    ticks(30);
    checks++;
    if (evq.size() - q0 != 0 || vcnt - v0 != 0) begin
      failures++;
      $display("FAIL rstmid_noevent got=ev%0d/v%0d exp=0/0",
               evq.size() - q0, vcnt - v0);
    end
    btn_noisy[0] = 1'b1;
    ticks(8);
    btn_noisy[0] = 1'b0;
    ticks(10);
    checks++;
    if (evq.size() - q0 != 1) begin
      failures++;
      $display("FAIL rstmid_newpress got=%0d exp=1",
               evq.size() - q0);
    end else begin
      checks++;
      if (evq[q0] !== 5'b000_01) begin
        failures++;
        $display("FAIL rstmid_newevt got=%b exp=00001", evq[q0]);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    btn_noisy = '0;
    evt_ready = 1'b1;
    test_reset();
    test_short();
    test_long();
    test_glitch();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
